// File: rtl/vector_mac_pkg.sv
// Shared types and the saturating-add helper for the vector MAC accumulator.
package vector_mac_pkg;

   // Widest accumulator the saturating adder supports.
   localparam int ACC_MAX = 64;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Tags that travel alongside the stage-1 products.
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } s1_tag_t;

   typedef struct packed {
      logic [ACC_MAX-1:0] sum;
      logic               sat;
   } sat_res_t;

   // Two guard bits so that neither a signed nor an unsigned sum can wrap.
   typedef logic signed [ACC_MAX+1:0] wide_t;

   // Adds a base and a product, both already extended to ACC_MAX bits, and
   // clamps the result to the range of an acc_width-bit accumulator.
   function automatic sat_res_t sat_add(input logic [ACC_MAX-1:0] base,
                                        input logic [ACC_MAX-1:0] prod,
                                        input logic               signed_mode,
                                        input int unsigned        acc_width);
      wide_t    sum;
      wide_t    hi;
      wide_t    lo;
      sat_res_t res;
      if (signed_mode) begin
         sum = wide_t'({{2{base[ACC_MAX-1]}}, base}) + wide_t'({{2{prod[ACC_MAX-1]}}, prod});
         hi  = (wide_t'(1) <<< (acc_width - 1)) - wide_t'(1);
         lo  = -(wide_t'(1) <<< (acc_width - 1));
      end else begin
         sum = wide_t'({2'b00, base}) + wide_t'({2'b00, prod});
         hi  = (wide_t'(1) <<< acc_width) - wide_t'(1);
         lo  = '0;
      end
      res.sum = sum[ACC_MAX-1:0];
      res.sat = 1'b0;
      if (sum > hi) begin
         res.sum = hi[ACC_MAX-1:0];
         res.sat = 1'b1;
      end else if (sum < lo) begin
         res.sum = lo[ACC_MAX-1:0];
         res.sat = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: product register, accumulator, sticky saturation and result hold.
module mac_lane #(
   parameter int REG_WIDTH = 16,
   parameter int ACC_WIDTH = 40
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 load_bias,
   input  logic                 beat_signed,
   input  logic [REG_WIDTH-1:0] a,
   input  logic [REG_WIDTH-1:0] b,
   input  logic [ACC_WIDTH-1:0] bias,
   input  logic                 s1_valid,
   input  logic                 s1_first,
   input  logic                 s1_last,
   input  logic                 s1_signed,
   output logic [ACC_WIDTH-1:0] c_out,
   output logic                 sat_flag
);
   import vector_mac_pkg::*;

   logic [2*REG_WIDTH-1:0] prod_d;
   logic [2*REG_WIDTH-1:0] prod_q;
   logic [ACC_WIDTH-1:0]   bias_q;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic [ACC_WIDTH-1:0]   base;
   logic [ACC_MAX-1:0]     base_ext;
   logic [ACC_MAX-1:0]     prod_ext;
   logic [ACC_WIDTH-1:0]   sum_c;
   logic                   sticky_q;
   logic                   sticky_d;
   sat_res_t               res;

   // Full-width product; sign-extending both operands first gives the signed product modulo 2^(2W).
   always_comb begin
      if (beat_signed) begin
         prod_d = {{REG_WIDTH{a[REG_WIDTH-1]}}, a} * {{REG_WIDTH{b[REG_WIDTH-1]}}, b};
      end else begin
         prod_d = {{REG_WIDTH{1'b0}}, a} * {{REG_WIDTH{1'b0}}, b};
      end
   end

   // Stage 1: register the product, and capture the bias only on a job's first beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         bias_q <= '0;
      end else if (en) begin
         prod_q <= prod_d;
         if (load_bias) begin
            bias_q <= bias;
         end
      end
   end

   // Stage-2 datapath: pick the base, extend per mode, saturating add, sticky update.
   always_comb begin
      base = s1_first ? bias_q : acc_q;
      if (s1_signed) begin
         base_ext = ACC_MAX'($signed(base));
         prod_ext = ACC_MAX'($signed(prod_q));
      end else begin
         base_ext = ACC_MAX'(base);
         prod_ext = ACC_MAX'(prod_q);
      end
      res      = sat_add(base_ext, prod_ext, s1_signed, ACC_WIDTH);
      sum_c    = res.sum[ACC_WIDTH-1:0];
      sticky_d = s1_first ? res.sat : (sticky_q | res.sat);
   end

   // Stage 2: accumulate, and publish the result on the job's last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         sticky_q <= 1'b0;
         c_out    <= '0;
         sat_flag <= 1'b0;
      end else if (en && s1_valid) begin
         acc_q    <= sum_c;
         sticky_q <= sticky_d;
         if (s1_last) begin
            c_out    <= sum_c;
            sat_flag <= sticky_d;
         end
      end
   end

endmodule

// File: rtl/vector_mac_acc.sv
// Vector MAC accumulator top: job FSM, beat counter, handshake and tag pipeline.
module vector_mac_acc #(
   parameter int REG_WIDTH = 16,
   parameter int VECTOR    = 8,
   parameter int ACC_WIDTH = 40,
   parameter int CNT_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [VECTOR-1:0][REG_WIDTH-1:0]  a_in,
   input  logic [VECTOR-1:0][REG_WIDTH-1:0]  b_in,
   input  logic [VECTOR-1:0][ACC_WIDTH-1:0]  bias_in,
   input  logic [CNT_WIDTH-1:0]              len_in,
   input  logic                              signed_mode,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [VECTOR-1:0][ACC_WIDTH-1:0]  c_out,
   output logic [VECTOR-1:0]                 sat_flag
);
   import vector_mac_pkg::*;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   if (ACC_WIDTH < 2 * REG_WIDTH || ACC_WIDTH > ACC_MAX) begin : g_bad_width
      $error("vector_mac_acc: ACC_WIDTH must be >= 2*REG_WIDTH and <= 64");
   end

   logic                 stall;
   logic                 en;
   logic                 accept;
   logic                 first_beat;
   logic                 beat_last;
   logic                 beat_signed;
   logic [CNT_WIDTH-1:0] len_eff;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 mode_q;
   state_t               state_q;
   s1_tag_t              tag_q;
   logic                 s1_signed_q;

   assign stall    = out_valid & ~out_ready;
   assign en       = ~stall & ~rst;
   assign in_ready = en;
   assign accept   = in_valid & en;

   // Decode the current beat: is it a job's first, its last, and which mode applies.
   always_comb begin
      len_eff     = (len_in == '0) ? CNT_ONE : len_in;
      first_beat  = (state_q == IDLE);
      beat_last   = first_beat ? (len_eff == CNT_ONE) : (cnt_q == CNT_ONE);
      beat_signed = first_beat ? signed_mode : mode_q;
   end

   // Job controller: latch length and mode on the first beat, count down the rest.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else if (accept) begin
         if (first_beat) begin
            mode_q <= signed_mode;
            if (len_eff != CNT_ONE) begin
               cnt_q   <= len_eff - CNT_ONE;
               state_q <= RUN;
            end
         end else begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_q <= IDLE;
            end
         end
      end
   end

   // Stage-1 tags travel in lockstep with the lane product registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q       <= '0;
         s1_signed_q <= 1'b0;
      end else if (en) begin
         tag_q.valid <= accept;
         tag_q.first <= accept & first_beat;
         tag_q.last  <= accept & beat_last;
         s1_signed_q <= beat_signed;
      end
   end

   // Result valid: set when a last beat leaves stage 2, cleared once taken downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else if (en && tag_q.valid && tag_q.last) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   for (genvar j = 0; j < VECTOR; j++) begin : g_lane
      mac_lane #(
         .REG_WIDTH (REG_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .load_bias   (accept & first_beat),
         .beat_signed (beat_signed),
         .a           (a_in[j]),
         .b           (b_in[j]),
         .bias        (bias_in[j]),
         .s1_valid    (tag_q.valid),
         .s1_first    (tag_q.first),
         .s1_last     (tag_q.last),
         .s1_signed   (s1_signed_q),
         .c_out       (c_out[j]),
         .sat_flag    (sat_flag[j])
      );
   end

endmodule

// File: tb/tb_vector_mac_acc.sv
// Self-checking bench for vector_mac_acc: directed cases plus randomized jobs against a job-level model.
module tb_vector_mac_acc;

   localparam int RW  = 16;
   localparam int VEC = 8;
   localparam int AW  = 40;
   localparam int CW  = 8;

   typedef logic [VEC-1:0][RW-1:0] op_t;
   typedef logic [VEC-1:0][AW-1:0] acc_t;

   typedef struct {
      acc_t           c;
      logic [VEC-1:0] sat;
      int             t;
   } res_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   op_t            a_in;
   op_t            b_in;
   acc_t           bias_in;
   logic [CW-1:0]  len_in;
   logic           signed_mode;
   logic           out_valid;
   logic           out_ready;
   acc_t           c_out;
   logic [VEC-1:0] sat_flag;

   int errors = 0;
   int checks = 0;

   res_t           expQ[$];
   longint         macc[VEC];
   logic [VEC-1:0] msat;
   bit             mActive = 0;
   int             mRemain = 0;
   bit             mSigned = 0;
   int             cycle = 0;
   int             xferCount = 0;
   bit             monOn = 0;
   bit             prevStall = 0;
   acc_t           prevC;
   logic [VEC-1:0] prevSat;
   bit             randReady = 0;

   vector_mac_acc #(
      .REG_WIDTH (RW),
      .VECTOR    (VEC),
      .ACC_WIDTH (AW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a_in        (a_in),
      .b_in        (b_in),
      .bias_in     (bias_in),
      .len_in      (len_in),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .c_out       (c_out),
      .sat_flag    (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checkOutput(name, 320'(act), 320'(exp));
   endtask

   function automatic op_t fillOp(input logic [RW-1:0] v);
      op_t o;
      for (int j = 0; j < VEC; j++) o[j] = v;
      return o;
   endfunction

   function automatic acc_t fillAcc(input logic [AW-1:0] v);
      acc_t o;
      for (int j = 0; j < VEC; j++) o[j] = v;
      return o;
   endfunction

   function automatic op_t randOp();
      op_t o;
      for (int j = 0; j < VEC; j++) begin
         case ($urandom_range(0, 5))
            0:       o[j] = 16'h8000;
            1:       o[j] = 16'h7FFF;
            2:       o[j] = 16'hFFFF;
            default: o[j] = RW'($urandom);
         endcase
      end
      return o;
   endfunction

   function automatic acc_t randBias();
      acc_t        o;
      logic [63:0] r;
      for (int j = 0; j < VEC; j++) begin
         r = {$urandom, $urandom};
         case ($urandom_range(0, 4))
            0:       o[j] = 40'h7F_FFFF_0000 + AW'(r[15:0]);
            1:       o[j] = 40'h80_0000_0000 + AW'(r[15:0]);
            2:       o[j] = 40'hFF_FFFF_0000 + AW'(r[15:0]);
            default: o[j] = r[AW-1:0];
         endcase
      end
      return o;
   endfunction

   // Accumulator step of the model: exact add, then clamp to the accumulator range.
   function automatic longint modelAdd(input longint acc, input longint p, input bit sgn, output bit sat);
      longint s;
      longint hi;
      longint lo;
      s   = acc + p;
      sat = 1'b0;
      if (sgn) begin
         hi = (longint'(1) <<< (AW - 1)) - 1;
         lo = -(longint'(1) <<< (AW - 1));
      end else begin
         hi = (longint'(1) <<< AW) - 1;
         lo = 0;
      end
      if (s > hi) begin
         s   = hi;
         sat = 1'b1;
      end else if (s < lo) begin
         s   = lo;
         sat = 1'b1;
      end
      return s;
   endfunction

   // Drives one beat at posedge+1 and holds it until the DUT accepts it.
   task automatic applyStimulus(input bit sm, input logic [CW-1:0] len, input op_t a, input op_t b, input acc_t bias);
      bit got = 0;
      signed_mode = sm;
      len_in      = len;
      a_in        = a;
      b_in        = b;
      bias_in     = bias;
      in_valid    = 1'b1;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL beat_accept_timeout: got in_ready=0 for 500 cycles required 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Expects the result of a beat accepted in the previous cycle to appear two cycles later.
   task automatic waitResult(input string name, input acc_t expC, input logic [VEC-1:0] expSat);
      @(negedge clk);
      @(negedge clk);
      checkBit({name, "_valid"}, out_valid, 1'b1);
      checkOutput({name, "_c"}, c_out, expC);
      checkOutput({name, "_sat"}, 320'(sat_flag), 320'(expSat));
      @(posedge clk);
      #1;
   endtask

   // Reference model and per-cycle compare process.
   always @(negedge clk) begin
      res_t   r;
      longint p;
      bit     s;
      if (monOn) begin
         cycle++;
         checkBit("in_ready", in_ready, !rst && !(out_valid && !out_ready));
         if (prevStall) begin
            checkBit("stall_hold_valid", out_valid, 1'b1);
            checkOutput("stall_hold_c", c_out, prevC);
            checkOutput("stall_hold_sat", 320'(sat_flag), 320'(prevSat));
         end
         if (!rst && out_valid && out_ready) begin
            xferCount++;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_result: got out_valid=1 required no pending result");
            end else begin
               r = expQ.pop_front();
               checkOutput("result_c", c_out, r.c);
               checkOutput("result_sat", 320'(sat_flag), 320'(r.sat));
               checkBit("result_latency", cycle >= r.t + 2, 1'b1);
            end
         end
         if (rst) begin
            expQ.delete();
            mActive = 0;
         end else if (in_valid && in_ready) begin
            if (!mActive) begin
               mRemain = (len_in == 0) ? 1 : int'(len_in);
               mSigned = signed_mode;
               msat    = '0;
               for (int j = 0; j < VEC; j++) begin
                  if (mSigned) macc[j] = longint'($signed(bias_in[j]));
                  else         macc[j] = longint'(bias_in[j]);
               end
               mActive = 1;
            end
            for (int j = 0; j < VEC; j++) begin
               if (mSigned) p = longint'($signed(a_in[j])) * longint'($signed(b_in[j]));
               else         p = longint'(a_in[j]) * longint'(b_in[j]);
               macc[j] = modelAdd(macc[j], p, mSigned, s);
               msat[j] = msat[j] | s;
            end
            mRemain--;
            if (mRemain == 0) begin
               for (int j = 0; j < VEC; j++) r.c[j] = macc[j][AW-1:0];
               r.sat = msat;
               r.t   = cycle;
               expQ.push_back(r);
               mActive = 0;
            end
         end
         prevStall = !rst && out_valid && !out_ready;
         prevC     = c_out;
         prevSat   = sat_flag;
      end
   end

   // Random downstream back-pressure, active only during the randomized phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReady) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish within time limit required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      op_t  ops;
      acc_t expC;
      int   x0;
      bit   seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; signed_mode = 1'b0;
      len_in = '0; a_in = '0; b_in = '0; bias_in = '0;

      @(posedge clk);
      #1;
      monOn = 1;
      @(negedge clk);
      checkBit("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_c_out", c_out, '0);
      checkOutput("reset_sat", 320'(sat_flag), '0);
      checkBit("reset_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // len=1 signed: 10 + 3*(-4) = -2 at t+2
      applyStimulus(1'b1, 8'd1, fillOp(16'd3), fillOp(16'hFFFC), fillAcc(40'd10));
      @(negedge clk);
      checkBit("t1_valid_early", out_valid, 1'b0);
      @(negedge clk);
      checkBit("t1_valid", out_valid, 1'b1);
      checkOutput("t1_c", c_out, fillAcc(40'hFF_FFFF_FFFE));
      checkOutput("t1_sat", 320'(sat_flag), '0);
      @(posedge clk);
      #1;

      // len=4 unsigned, lane j: a=b=j+1 -> 4*(j+1)^2, one pulse
      x0 = xferCount;
      for (int j = 0; j < VEC; j++) begin
         ops[j]  = RW'(j + 1);
         expC[j] = AW'(4 * (j + 1) * (j + 1));
      end
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'd4, ops, ops, fillAcc(40'd0));
      signed_mode = 1'b0; len_in = 8'd4; a_in = ops; b_in = ops; bias_in = '0; in_valid = 1'b1;
      @(negedge clk);
      checkBit("t2_last_accept", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitResult("t2", expC, '0);
      repeat (3) @(negedge clk);
      checkOutput("t2_pulses", 320'(xferCount - x0), 320'(1));
      @(posedge clk);
      #1;

      // signed saturation to max, then a clean job
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'd4, fillOp(16'h8000), fillOp(16'h8000), fillAcc(40'h7F_8000_0000));
      signed_mode = 1'b1; a_in = fillOp(16'h8000); b_in = fillOp(16'h8000); in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitResult("t3_sat", fillAcc(40'h7F_FFFF_FFFF), '1);
      signed_mode = 1'b1; len_in = 8'd1; a_in = fillOp(16'd1); b_in = fillOp(16'd1); bias_in = '0; in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitResult("t3_clean", fillAcc(40'd1), '0);

      // clamp then continue from the clamped value; unsigned max; signed min
      applyStimulus(1'b1, 8'd2, fillOp(16'd1), fillOp(16'd1), fillAcc(40'h7F_FFFF_FFFF));
      signed_mode = 1'b0; len_in = 8'd7; a_in = fillOp(16'hFFFF); b_in = fillOp(16'd1); bias_in = '0; in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitResult("t3_continue", fillAcc(40'h7F_FFFF_FFFE), '1);
      signed_mode = 1'b0; len_in = 8'd1; a_in = fillOp(16'd1); b_in = fillOp(16'd1); bias_in = fillAcc(40'hFF_FFFF_FFFF); in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitResult("t3_umax", fillAcc(40'hFF_FFFF_FFFF), '1);
      signed_mode = 1'b1; len_in = 8'd1; a_in = fillOp(16'd1); b_in = fillOp(16'hFFFF); bias_in = fillAcc(40'h80_0000_0000); in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitResult("t3_smin", fillAcc(40'h80_0000_0000), '1);

      // stall: result pending with out_ready=0 while the next beat is held
      x0 = xferCount;
      out_ready = 1'b0;
      applyStimulus(1'b0, 8'd1, fillOp(16'd2), fillOp(16'd3), fillAcc(40'd0));
      applyStimulus(1'b0, 8'd1, fillOp(16'd4), fillOp(16'd4), fillAcc(40'd0));
      signed_mode = 1'b0; len_in = 8'd1; a_in = fillOp(16'd5); b_in = fillOp(16'd5); bias_in = '0; in_valid = 1'b1;
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      checkBit("t4_result_seen", seen, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         checkBit("t4_in_ready_low", in_ready, 1'b0);
         checkOutput("t4_c_hold", c_out, fillAcc(40'd6));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      checkBit("t4_resume_accept", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("t4_xfers", 320'(xferCount - x0), 320'(3));
      checkBit("t4_queue_empty", expQ.size() == 0, 1'b1);
      @(posedge clk);
      #1;

      // reset mid-job discards it; next job is fresh
      applyStimulus(1'b0, 8'd4, fillOp(16'd1), fillOp(16'd1), fillAcc(40'd0));
      applyStimulus(1'b0, 8'd4, fillOp(16'd1), fillOp(16'd1), fillAcc(40'd0));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkBit("t5_no_output", out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      signed_mode = 1'b0; len_in = 8'd1; a_in = fillOp(16'd2); b_in = fillOp(16'd5); bias_in = fillAcc(40'd1); in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitResult("t5", fillAcc(40'd11), '0);

      // len_in=0 jobs alternating signed/unsigned, one result per cycle
      fork
         begin
            for (int i = 0; i < 6; i++)
               applyStimulus(i % 2 == 0, 8'd0, fillOp(16'hFFFF), fillOp(16'd1), fillAcc(40'd0));
         end
         begin
            @(negedge clk);
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               checkBit("t6_valid", out_valid, 1'b1);
               checkOutput("t6_c", c_out, (i % 2 == 0) ? fillAcc(40'hFF_FFFF_FFFF) : fillAcc(40'd65535));
            end
         end
      join
      @(posedge clk);
      #1;

      // randomized jobs with gaps, mid-job field changes and back-pressure
      randReady = 1;
      for (int n = 0; n < 60; n++) begin
         int   len;
         bit   sm;
         acc_t bias;
         len  = $urandom_range(1, 5);
         sm   = 1'($urandom_range(0, 1));
         bias = randBias();
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
            if (k == 0)
               applyStimulus(sm, (len == 1 && $urandom_range(0, 1) == 1) ? '0 : CW'(len), randOp(), randOp(), bias);
            else
               applyStimulus(1'($urandom_range(0, 1)), CW'($urandom_range(0, 255)), randOp(), randOp(), randBias());
         end
      end
      randReady = 0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (20) @(negedge clk);
      checkBit("drain_empty", expQ.size() == 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vector_mac_acc.md
Name: vector_mac_acc

Overview:
- Parametrised successor to the per-lane vector MAC in the reconfigurable PE.
- VECTOR parallel lanes multiply REG_WIDTH operands and accumulate over a programmable number of beats (a "job") into ACC_WIDTH accumulators, seeded by a per-lane bias.
- Adds over the previous generation: valid/ready handshake, a 2-stage pipeline, signed/unsigned mode, and a saturation flag.
- Feeds PE output collection logic.

Parameters:
- REG_WIDTH, 16, operand width per lane.
- VECTOR, 8, lane count.
- ACC_WIDTH, 40, accumulator/result width; must be >= 2*REG_WIDTH (elaboration-time assertion).
- CNT_WIDTH, 8, width of job length field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a_in  in  REG_WIDTH x VECTOR  operand A per lane.
- b_in  in  REG_WIDTH x VECTOR  operand B per lane.
- bias_in  in  ACC_WIDTH x VECTOR  initial accumulator value; sampled on the first beat of a job.
- len_in  in  CNT_WIDTH  beats per job; sampled on the first beat; 0 is treated as 1.
- signed_mode  in  1  1 = two's-complement, 0 = unsigned; sampled on the first beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- c_out  out  ACC_WIDTH x VECTOR  accumulated result per lane.
- sat_flag  out  VECTOR  per-lane flag: saturation occurred during the job.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: out_valid=0, c_out=0, sat_flag=0, beat counter=0, FSM=IDLE, stage-1 valid=0.
- in_ready is 0 while rst=1.
- Stall: stall = out_valid & ~out_ready; en = ~stall & ~rst; in_ready = en.
- Handshakes:
  - A beat is accepted when in_valid & in_ready.
  - The result transfers when out_valid & out_ready.
  - out_valid deasserts on transfer unless a new result completes in the same cycle; in that case c_out is reloaded and out_valid stays 1.
- Controller FSM, advancing only when en=1:
  - IDLE: an accepted beat is the first beat. It latches len (0→1), signed_mode and bias, and tags first=1. If len<=1 it also tags last=1 and stays in IDLE; else counter=len-1 and go to RUN.
  - RUN: each accepted beat decrements the counter. The beat arriving at counter==1 is tagged last and the FSM returns to IDLE. With no accepted beat, the FSM holds.
- Stage 1, registered when en:
  - product[j] = a_in[j]*b_in[j], 2*REG_WIDTH bits, signed or unsigned per the latched mode.
  - Also registers the first/last tags and a valid bit.
- Stage 2, per lane, when en and stage-1 valid:
  - base = first ? bias : acc.
  - sum = base + extend(product): sign-extended if signed, zero-extended otherwise; computed at ACC_WIDTH+1 bits.
- Saturation:
  - Signed overflow clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - Unsigned overflow clamps to 2^ACC_WIDTH-1.
  - Any clamp sets the lane's sticky sat bit. The sticky bit is cleared at a first beat, which takes its value from that beat's clamp only.
  - The accumulator stays clamped; later beats continue from the clamped value.
- Output: on a last-tagged stage-2 update, c_out <= clamped sum, sat_flag <= sticky bit, out_valid <= 1.
- Latency: last beat accepted at cycle t → out_valid=1 at t+2 if unstalled.
- Throughput: 1 beat/cycle. Back-to-back jobs need no bubble.
- Stall behaviour: stage 1, stage 2, FSM and counter all freeze. c_out and sat_flag hold stable while out_valid=1.
- in_valid low mid-job: the job pauses indefinitely with no timeout.
- Mid-job input changes: signed_mode, len_in and bias_in changes after the first beat are ignored until the next job.
- Reset mid-job: the job is discarded with no output. The next accepted beat is a first beat.

Decomposition:
- Package vector_mac_pkg holds:
  - the FSM state enum (IDLE, RUN);
  - a stage-1 tag struct (valid, first, last);
  - a function sat_add(base, prod, signed_mode) returning {clamped sum, sat}.
- Sub-module mac_lane:
  - one lane, holding the product register, accumulator, sticky sat and saturation logic;
  - instantiated VECTOR times by a generate loop.
- The top level holds the FSM, counter, handshake and tag pipeline.

Test Plan:
- len=1, signed, all lanes a=3, b=-4, bias=10; out_ready=1 → c_out=-2 in every lane at t+2, sat_flag=0.
- len=4, unsigned, lane j a=b=j+1 for all beats, bias=0, beats on consecutive cycles → single result c_out[j]=4*(j+1)^2, exactly one out_valid pulse.
- ACC_WIDTH=32, signed, a=b=-32768, len=4, bias=0 → c_out=0x7FFFFFFF, sat_flag all 1. Next job: len=1, a=1, b=1, bias=0 → c_out=1, sat_flag=0.
- Result pending with out_ready=0 for 5 cycles, in_valid=1 held → in_ready=0 and c_out stable for all 5 cycles. Then out_ready=1 → next job's result correct, no beat lost or duplicated.
- After 2 of 4 beats, rst for 1 cycle → out_valid stays 0. Then a len=1 job with a=2, b=5, bias=1 → c_out=11.
- len_in=0 → treated as 1. Alternate signed/unsigned len=1 jobs every cycle with a=0xFFFF, b=1, bias=0: signed gives -1, unsigned gives 65535, one result per cycle.
